// File: rtl/id_issue_stage_if.sv
// Fetch, register-file read, writeback-snoop and EX-payload signals of the decode/issue stage.
// The slave modport is the stage side; the master modport is the environment side.
interface id_issue_stage_if #(
  parameter int RADDR_WIDTH = 5,
  parameter int RDATA_WIDTH = 32
);
  logic                   inst_valid_i;
  logic                   inst_ready_o;
  logic [31:0]            inst_i;
  logic [31:0]            pc_i;
  logic                   re1_o;
  logic [RADDR_WIDTH-1:0] raddr1_o;
  logic                   re2_o;
  logic [RADDR_WIDTH-1:0] raddr2_o;
  logic [RDATA_WIDTH-1:0] rdata1_i;
  logic [RDATA_WIDTH-1:0] rdata2_i;
  logic                   wb_we_i;
  logic [RADDR_WIDTH-1:0] wb_waddr_i;
  logic                   ex_valid_o;
  logic                   ex_ready_i;
  logic [3:0]             ex_aluop_o;
  logic [RDATA_WIDTH-1:0] ex_op1_o;
  logic [RDATA_WIDTH-1:0] ex_op2_o;
  logic [RADDR_WIDTH-1:0] ex_wd_o;
  logic                   ex_wreg_o;
  logic [31:0]            ex_pc_o;
  logic                   ex_illegal_o;

  modport slave (
    input  inst_valid_i, inst_i, pc_i, rdata1_i, rdata2_i, wb_we_i, wb_waddr_i, ex_ready_i,
    output inst_ready_o, re1_o, raddr1_o, re2_o, raddr2_o, ex_valid_o, ex_aluop_o,
           ex_op1_o, ex_op2_o, ex_wd_o, ex_wreg_o, ex_pc_o, ex_illegal_o
  );

  modport master (
    output inst_valid_i, inst_i, pc_i, rdata1_i, rdata2_i, wb_we_i, wb_waddr_i, ex_ready_i,
    input  inst_ready_o, re1_o, raddr1_o, re2_o, raddr2_o, ex_valid_o, ex_aluop_o,
           ex_op1_o, ex_op2_o, ex_wd_o, ex_wreg_o, ex_pc_o, ex_illegal_o
  );
endinterface

// File: rtl/id_issue_stage.sv
// RV32 OP-IMM/OP/LUI decode and issue with per-register pending-writeback interlock.
// One cycle from handshake to ex_valid_o; stalls on operand/rd hazard, flush or EX backpressure.
module id_issue_stage #(
  parameter int RADDR_WIDTH = 5,
  parameter int RDATA_WIDTH = 32,
  parameter int RNUM        = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  id_issue_stage_if.slave    bus
);

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_OR = 4'd6, ALU_AND = 4'd7,
    ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11
  } aluop_e;

  typedef struct packed {
    logic [3:0]             aluop;
    logic [RDATA_WIDTH-1:0] op1;
    logic [RDATA_WIDTH-1:0] op2;
    logic [RADDR_WIDTH-1:0] wd;
    logic                   wreg;
    logic [31:0]            pc;
    logic                   illegal;
  } ex_payload_t;

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic [6:0]             opcode, funct7;
  logic [2:0]             funct3;
  logic [RADDR_WIDTH-1:0] rs1, rs2, rd;
  logic                   dec_re1, dec_re2, dec_illegal, dec_wreg, use_imm, op1_zero;
  aluop_e                 dec_aluop;
  logic [31:0]            imm32;

  ex_payload_t            ex_q, ex_d, new_payload;
  logic                   ex_valid_q, ex_valid_d;
  logic [RNUM-1:0][1:0]   cnt_q, cnt_d;
  logic                   hz_rs1, hz_rs2, hz_rd, hazard, inst_ready, capture, flush_kill;

  assign opcode = bus.inst_i[6:0];
  assign funct3 = bus.inst_i[14:12];
  assign funct7 = bus.inst_i[31:25];
  assign rs1    = RADDR_WIDTH'(bus.inst_i[19:15]);
  assign rs2    = RADDR_WIDTH'(bus.inst_i[24:20]);
  assign rd     = RADDR_WIDTH'(bus.inst_i[11:7]);

  always_comb begin
    dec_re1     = 1'b0;
    dec_re2     = 1'b0;
    dec_illegal = 1'b0;
    dec_aluop   = ALU_NOP;
    use_imm     = 1'b0;
    op1_zero    = 1'b0;
    imm32       = {{20{bus.inst_i[31]}}, bus.inst_i[31:20]};
    unique case (opcode)
      OPC_OPIMM: begin
        dec_re1 = 1'b1;
        use_imm = 1'b1;
        unique case (funct3)
          3'b000: dec_aluop = ALU_ADD;
          3'b010: dec_aluop = ALU_SLT;
          3'b011: dec_aluop = ALU_SLTU;
          3'b100: dec_aluop = ALU_XOR;
          3'b110: dec_aluop = ALU_OR;
          3'b111: dec_aluop = ALU_AND;
          3'b001: begin
            imm32       = {27'b0, bus.inst_i[24:20]};
            dec_aluop   = ALU_SLL;
            dec_illegal = (funct7 != F7_BASE);
          end
          default: begin
            imm32       = {27'b0, bus.inst_i[24:20]};
            dec_aluop   = bus.inst_i[30] ? ALU_SRA : ALU_SRL;
            dec_illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
          end
        endcase
      end
      OPC_OP: begin
        dec_re1 = 1'b1;
        dec_re2 = 1'b1;
        if (funct7 == F7_BASE) begin
          unique case (funct3)
            3'b000:  dec_aluop = ALU_ADD;
            3'b001:  dec_aluop = ALU_SLL;
            3'b010:  dec_aluop = ALU_SLT;
            3'b011:  dec_aluop = ALU_SLTU;
            3'b100:  dec_aluop = ALU_XOR;
            3'b101:  dec_aluop = ALU_SRL;
            3'b110:  dec_aluop = ALU_OR;
            default: dec_aluop = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_aluop = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_aluop = ALU_SRA;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        use_imm   = 1'b1;
        op1_zero  = 1'b1;
        imm32     = {bus.inst_i[31:12], 12'b0};
        dec_aluop = ALU_LUI;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_re1   = 1'b0;
      dec_re2   = 1'b0;
      dec_aluop = ALU_NOP;
    end
  end

  assign dec_wreg = !dec_illegal && (rd != '0);

  assign bus.re1_o    = dec_re1 && bus.inst_valid_i;
  assign bus.re2_o    = dec_re2 && bus.inst_valid_i;
  assign bus.raddr1_o = rs1;
  assign bus.raddr2_o = rs2;

  // A source whose only outstanding write retires this cycle is served by the regfile bypass.
  assign hz_rs1 = bus.re1_o && (cnt_q[rs1] != 2'd0) &&
                  !(bus.wb_we_i && bus.wb_waddr_i == rs1 && cnt_q[rs1] == 2'd1);
  assign hz_rs2 = bus.re2_o && (cnt_q[rs2] != 2'd0) &&
                  !(bus.wb_we_i && bus.wb_waddr_i == rs2 && cnt_q[rs2] == 2'd1);
  assign hz_rd  = bus.inst_valid_i && dec_wreg && (cnt_q[rd] == 2'd3);
  assign hazard = hz_rs1 || hz_rs2 || hz_rd;

  assign inst_ready       = !rst_i && !flush_i && !hazard && (!ex_valid_q || bus.ex_ready_i);
  assign bus.inst_ready_o = inst_ready;
  assign capture          = bus.inst_valid_i && inst_ready;
  assign flush_kill       = flush_i && ex_valid_q && ex_q.wreg;

  always_comb begin
    new_payload         = '0;
    new_payload.aluop   = dec_aluop;
    new_payload.wd      = rd;
    new_payload.wreg    = dec_wreg;
    new_payload.pc      = bus.pc_i;
    new_payload.illegal = dec_illegal;
    if (!dec_illegal) begin
      new_payload.op1 = op1_zero ? '0 : bus.rdata1_i;
      new_payload.op2 = use_imm ? RDATA_WIDTH'($signed(imm32)) : bus.rdata2_i;
    end

    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (capture) begin
      ex_d       = new_payload;
      ex_valid_d = 1'b1;
    end else if (flush_i || (ex_valid_q && bus.ex_ready_i)) begin
      ex_valid_d = 1'b0;
    end
  end

  // Issue, writeback and flush deltas sum per register, clamped to the 2-bit range.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 1; i < RNUM; i++) begin
      logic [2:0] up;
      logic [2:0] down;
      up   = {1'b0, cnt_q[i]} + {2'b0, (capture && dec_wreg && rd == RADDR_WIDTH'(i))};
      down = {2'b0, (bus.wb_we_i && bus.wb_waddr_i == RADDR_WIDTH'(i))} +
             {2'b0, (flush_kill && ex_q.wd == RADDR_WIDTH'(i))};
      if (up < down)               cnt_d[i] = 2'd0;
      else if (up - down > 3'd3)   cnt_d[i] = 2'd3;
      else                         cnt_d[i] = 2'(up - down);
    end
    cnt_d[0] = 2'd0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.ex_valid_o   = ex_valid_q;
  assign bus.ex_aluop_o   = ex_q.aluop;
  assign bus.ex_op1_o     = ex_q.op1;
  assign bus.ex_op2_o     = ex_q.op2;
  assign bus.ex_wd_o      = ex_q.wd;
  assign bus.ex_wreg_o    = ex_q.wreg;
  assign bus.ex_pc_o      = ex_q.pc;
  assign bus.ex_illegal_o = ex_q.illegal;

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage: reset, issue, RAW interlock with bypass, backpressure,
// flush with concurrent writeback, illegal encodings, LUI and pending-counter saturation.
module tb_id_issue_stage;
  logic clk_i = 1'b0;
  logic rst_i;
  logic flush_i;
  int   checks   = 0;
  int   failures = 0;

  id_issue_stage_if #(.RADDR_WIDTH(5), .RDATA_WIDTH(32)) bus ();

  id_issue_stage #(.RADDR_WIDTH(5), .RDATA_WIDTH(32), .RNUM(32)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    flush_i = 1'b0;
    bus.inst_valid_i = 1'b0;
    bus.inst_i = 32'h0;
    bus.pc_i = 32'h0;
    bus.rdata1_i = 32'h0;
    bus.rdata2_i = 32'h0;
    bus.wb_we_i = 1'b0;
    bus.wb_waddr_i = 5'd0;
    bus.ex_ready_i = 1'b1;
    #2;
    chk("reset_ex_valid", 32'(bus.ex_valid_o), 32'd0);
    chk("reset_ready", 32'(bus.inst_ready_o), 32'd0);
    chk("reset_cnt1", 32'(dut.cnt_q[1]), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();

    // ORI x1,x0,0x5A5
    bus.inst_i = 32'h5A506093; bus.pc_i = 32'h100; bus.inst_valid_i = 1'b1; #1;
    chk("ori_ready", 32'(bus.inst_ready_o), 32'd1);
    chk("ori_re1", 32'(bus.re1_o), 32'd1);
    chk("ori_re2", 32'(bus.re2_o), 32'd0);
    tick();

    // ADDI x2,x1,1 back-to-back: stalls on x1
    bus.inst_i = 32'h00108113; bus.pc_i = 32'h104; bus.rdata1_i = 32'hDEAD; #1;
    chk("ori_ex_valid", 32'(bus.ex_valid_o), 32'd1);
    chk("ori_aluop", 32'(bus.ex_aluop_o), 32'd6);
    chk("ori_op1", bus.ex_op1_o, 32'h0);
    chk("ori_op2", bus.ex_op2_o, 32'h000005A5);
    chk("ori_wd", 32'(bus.ex_wd_o), 32'd1);
    chk("ori_wreg", 32'(bus.ex_wreg_o), 32'd1);
    chk("ori_pc", bus.ex_pc_o, 32'h100);
    chk("ori_cnt1", 32'(dut.cnt_q[1]), 32'd1);
    chk("addi_stall_ready", 32'(bus.inst_ready_o), 32'd0);
    chk("addi_raddr1", 32'(bus.raddr1_o), 32'd1);
    tick();
    chk("ori_drained", 32'(bus.ex_valid_o), 32'd0);
    chk("addi_still_stalled", 32'(bus.inst_ready_o), 32'd0);
    bus.wb_we_i = 1'b1; bus.wb_waddr_i = 5'd1; bus.rdata1_i = 32'h5A5; #1;
    chk("addi_wb_ready", 32'(bus.inst_ready_o), 32'd1);
    tick();
    bus.wb_we_i = 1'b0; bus.inst_valid_i = 1'b0;
    chk("addi_ex_valid", 32'(bus.ex_valid_o), 32'd1);
    chk("addi_aluop", 32'(bus.ex_aluop_o), 32'd1);
    chk("addi_op1_bypass", bus.ex_op1_o, 32'h5A5);
    chk("addi_op2", bus.ex_op2_o, 32'h1);
    chk("addi_wd", 32'(bus.ex_wd_o), 32'd2);
    chk("addi_pc", bus.ex_pc_o, 32'h104);
    chk("addi_cnt1", 32'(dut.cnt_q[1]), 32'd0);
    chk("addi_cnt2", 32'(dut.cnt_q[2]), 32'd1);

    // EX backpressure with LUI x5,0x12345 waiting
    bus.ex_ready_i = 1'b0;
    bus.inst_i = 32'h123452B7; bus.pc_i = 32'h108; bus.inst_valid_i = 1'b1; #1;
    chk("bp_ready", 32'(bus.inst_ready_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_valid", 32'(bus.ex_valid_o), 32'd1);
      chk("bp_hold_op1", bus.ex_op1_o, 32'h5A5);
      chk("bp_hold_wd", 32'(bus.ex_wd_o), 32'd2);
      chk("bp_hold_ready", 32'(bus.inst_ready_o), 32'd0);
      chk("bp_cnt5", 32'(dut.cnt_q[5]), 32'd0);
      chk("bp_cnt2", 32'(dut.cnt_q[2]), 32'd1);
    end
    bus.ex_ready_i = 1'b1; #1;
    chk("bp_release_ready", 32'(bus.inst_ready_o), 32'd1);
    tick();

    // ORI x3,x0,7 twice, back-to-back at full rate
    bus.inst_i = 32'h00706193; bus.pc_i = 32'h10C; #1;
    chk("lui_aluop", 32'(bus.ex_aluop_o), 32'd11);
    chk("lui_op1", bus.ex_op1_o, 32'h0);
    chk("lui_op2", bus.ex_op2_o, 32'h12345000);
    chk("lui_wd", 32'(bus.ex_wd_o), 32'd5);
    chk("lui_cnt5", 32'(dut.cnt_q[5]), 32'd1);
    chk("ori3a_ready", 32'(bus.inst_ready_o), 32'd1);
    tick();
    bus.pc_i = 32'h110; #1;
    chk("ori3a_wd", 32'(bus.ex_wd_o), 32'd3);
    chk("ori3a_cnt3", 32'(dut.cnt_q[3]), 32'd1);
    chk("ori3b_ready", 32'(bus.inst_ready_o), 32'd1);
    tick();
    bus.inst_valid_i = 1'b0; bus.ex_ready_i = 1'b0; #1;
    chk("ori3b_cnt3", 32'(dut.cnt_q[3]), 32'd2);
    chk("ori3b_pc", bus.ex_pc_o, 32'h110);

    // Flush held ORI x3 while older x3 write retires; ADDI x9 must not be captured
    flush_i = 1'b1; bus.wb_we_i = 1'b1; bus.wb_waddr_i = 5'd3;
    bus.inst_i = 32'h00100493; bus.inst_valid_i = 1'b1; #1;
    chk("flush_ready", 32'(bus.inst_ready_o), 32'd0);
    tick();
    flush_i = 1'b0; bus.wb_we_i = 1'b0; bus.inst_valid_i = 1'b0;
    chk("flush_ex_valid", 32'(bus.ex_valid_o), 32'd0);
    chk("flush_cnt3", 32'(dut.cnt_q[3]), 32'd0);
    chk("flush_cnt9", 32'(dut.cnt_q[9]), 32'd0);

    // Illegal opcode
    bus.ex_ready_i = 1'b1;
    bus.inst_i = 32'hFFFFFFFF; bus.pc_i = 32'h200; bus.inst_valid_i = 1'b1; #1;
    chk("ill_re1", 32'(bus.re1_o), 32'd0);
    chk("ill_re2", 32'(bus.re2_o), 32'd0);
    chk("ill_ready", 32'(bus.inst_ready_o), 32'd1);
    tick();
    bus.inst_valid_i = 1'b0;
    chk("ill_flag", 32'(bus.ex_illegal_o), 32'd1);
    chk("ill_aluop", 32'(bus.ex_aluop_o), 32'd0);
    chk("ill_wreg", 32'(bus.ex_wreg_o), 32'd0);
    chk("ill_cnt31", 32'(dut.cnt_q[31]), 32'd0);

    // SUB x6,x1,x2 stalls on rs2 until x2 retires
    bus.inst_i = 32'h40208333; bus.pc_i = 32'h204; bus.inst_valid_i = 1'b1;
    bus.rdata1_i = 32'h10; bus.rdata2_i = 32'h3; #1;
    chk("sub_re2", 32'(bus.re2_o), 32'd1);
    chk("sub_raddr2", 32'(bus.raddr2_o), 32'd2);
    chk("sub_stall", 32'(bus.inst_ready_o), 32'd0);
    bus.wb_we_i = 1'b1; bus.wb_waddr_i = 5'd2; #1;
    chk("sub_wb_ready", 32'(bus.inst_ready_o), 32'd1);
    tick();
    bus.wb_we_i = 1'b0;
    chk("sub_aluop", 32'(bus.ex_aluop_o), 32'd2);
    chk("sub_op1", bus.ex_op1_o, 32'h10);
    chk("sub_op2", bus.ex_op2_o, 32'h3);
    chk("sub_wd", 32'(bus.ex_wd_o), 32'd6);
    chk("sub_cnt2", 32'(dut.cnt_q[2]), 32'd0);
    chk("sub_cnt6", 32'(dut.cnt_q[6]), 32'd1);

    // OP with funct7=0000001 is illegal
    bus.inst_i = 32'h02208333; #1;
    chk("mul_re1", 32'(bus.re1_o), 32'd0);
    tick();
    chk("mul_illegal", 32'(bus.ex_illegal_o), 32'd1);
    chk("mul_cnt6", 32'(dut.cnt_q[6]), 32'd1);

    // SRAI x7,x1,3
    bus.inst_i = 32'h4030D393; bus.rdata1_i = 32'h80000000;
    tick();
    bus.inst_valid_i = 1'b0;
    chk("srai_aluop", 32'(bus.ex_aluop_o), 32'd10);
    chk("srai_op1", bus.ex_op1_o, 32'h80000000);
    chk("srai_op2", bus.ex_op2_o, 32'h3);

    // ADDI x9,x0,1 three times saturates cnt[9]; the fourth is blocked
    bus.inst_i = 32'h00100493; bus.inst_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("sat_ready", 32'(bus.inst_ready_o), 32'd1);
      tick();
    end
    chk("sat_cnt9", 32'(dut.cnt_q[9]), 32'd3);
    chk("sat_blocked", 32'(bus.inst_ready_o), 32'd0);

    // Asynchronous reset between edges
    #1;
    rst_i = 1'b1; #1;
    chk("arst_ex_valid", 32'(bus.ex_valid_o), 32'd0);
    chk("arst_cnt9", 32'(dut.cnt_q[9]), 32'd0);
    chk("arst_cnt7", 32'(dut.cnt_q[7]), 32'd0);
    chk("arst_ready", 32'(bus.inst_ready_o), 32'd0);
    tick();
    rst_i = 1'b0;
    bus.inst_valid_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
